// File: rtl/sfifo_sp_ctrl.sv
// Pointer, flag and arbitration controller for a FIFO built on a single-port SRAM.
// Serialises SRAM traffic through a 1-entry write buffer and a 2-entry output prefetch buffer.
module sfifo_sp_ctrl #(
  parameter int unsigned BW     = 48,
  parameter int unsigned LGFLEN = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_wr,
  input  logic [BW-1:0]     i_data,
  output logic              o_full,
  output logic              o_ovf,
  output logic [LGFLEN+1:0] o_fill,
  output logic              o_valid,
  output logic [BW-1:0]     o_data,
  input  logic              i_ready,
  output logic              o_mem_wr,
  output logic [LGFLEN:0]   o_mem_wr_addr,
  output logic [BW-1:0]     o_mem_data,
  output logic              o_mem_rd,
  output logic [LGFLEN:0]   o_mem_rd_addr,
  input  logic [BW-1:0]     i_mem_data
);

  localparam int unsigned PW = LGFLEN + 1;
  localparam int unsigned FW = LGFLEN + 2;

  typedef enum logic {GntWr, GntRd} gnt_e;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [BW-1:0] wbuf_q, wbuf_d;
  logic          wbuf_v_q, wbuf_v_d;
  logic [BW-1:0] obuf0_q, obuf0_d, obuf1_q, obuf1_d;
  logic [1:0]    ocnt_q, ocnt_d;
  logic          rd_inflt_q, rd_inflt_d;
  gnt_e          last_gnt_q, last_gnt_d;

  logic [PW-1:0] mem_cnt;
  logic [FW-1:0] fill;
  logic          wr_req, rd_req, wr_gnt, rd_gnt, accept, pop;

  always_comb begin
    mem_cnt = wr_ptr_q - rd_ptr_q;
    // mem_cnt never exceeds DEPTH, so its MSB alone flags a full SRAM.
    wr_req  = wbuf_v_q && !mem_cnt[LGFLEN];
    rd_req  = (mem_cnt != '0) && ((ocnt_q + {1'b0, rd_inflt_q}) < 2'd2);
    wr_gnt  = wr_req && (!rd_req || (last_gnt_q == GntRd));
    rd_gnt  = rd_req && !wr_gnt;
    accept  = i_wr && (!wbuf_v_q || wr_gnt);
    pop     = (ocnt_q != 2'd0) && i_ready;
    fill    = {1'b0, mem_cnt} + FW'(ocnt_q) + FW'(wbuf_v_q) + FW'(rd_inflt_q);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wbuf_d     = wbuf_q;
    wbuf_v_d   = wbuf_v_q;
    obuf0_d    = obuf0_q;
    obuf1_d    = obuf1_q;
    ocnt_d     = ocnt_q;
    rd_inflt_d = rd_gnt;
    last_gnt_d = last_gnt_q;

    if (wr_gnt) begin
      wr_ptr_d   = wr_ptr_q + PW'(1);
      last_gnt_d = GntWr;
    end
    if (rd_gnt) begin
      rd_ptr_d   = rd_ptr_q + PW'(1);
      last_gnt_d = GntRd;
    end

    if (accept) begin
      wbuf_d   = i_data;
      wbuf_v_d = 1'b1;
    end else if (wr_gnt) begin
      wbuf_v_d = 1'b0;
    end

    // A return never arrives with ocnt == 2: the read request reserves its slot.
    if (rd_inflt_q && pop) begin
      if (ocnt_q == 2'd2) begin
        obuf0_d = obuf1_q;
        obuf1_d = i_mem_data;
      end else begin
        obuf0_d = i_mem_data;
      end
    end else if (rd_inflt_q) begin
      if (ocnt_q == 2'd0) begin
        obuf0_d = i_mem_data;
      end else begin
        obuf1_d = i_mem_data;
      end
      ocnt_d = ocnt_q + 2'd1;
    end else if (pop) begin
      obuf0_d = obuf1_q;
      ocnt_d  = ocnt_q - 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wbuf_v_q   <= 1'b0;
      ocnt_q     <= 2'd0;
      rd_inflt_q <= 1'b0;
      last_gnt_q <= GntRd;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wbuf_v_q   <= wbuf_v_d;
      ocnt_q     <= ocnt_d;
      rd_inflt_q <= rd_inflt_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // Data registers need no reset; their valid bits gate every use.
  always_ff @(posedge i_clk) begin
    wbuf_q  <= wbuf_d;
    obuf0_q <= obuf0_d;
    obuf1_q <= obuf1_d;
  end

  always_comb begin
    o_mem_wr      = i_reset_n && wr_gnt;
    o_mem_wr_addr = {1'b0, wr_ptr_q[LGFLEN-1:0]};
    o_mem_data    = wbuf_q;
    o_mem_rd      = i_reset_n && rd_gnt;
    o_mem_rd_addr = {1'b0, rd_ptr_q[LGFLEN-1:0]};
    o_full        = !i_reset_n || (wbuf_v_q && !wr_gnt);
    o_ovf         = i_reset_n && i_wr && wbuf_v_q && !wr_gnt;
    o_valid       = i_reset_n && (ocnt_q != 2'd0);
    o_data        = obuf0_q;
    o_fill        = i_reset_n ? fill : '0;
  end

endmodule

// File: tb/tb_sfifo_sp_ctrl.sv
// Self-checking bench for sfifo_sp_ctrl: SRAM model, cycle-level scoreboard and directed tests.
module tb_sfifo_sp_ctrl;

  localparam int unsigned BW     = 48;
  localparam int unsigned LGFLEN = 4;
  localparam int unsigned DEPTH  = 16;

  logic              clk = 1'b0;
  logic              i_reset_n;
  logic              i_wr;
  logic [BW-1:0]     i_data;
  logic              o_full, o_ovf, o_valid, i_ready;
  logic [LGFLEN+1:0] o_fill;
  logic [BW-1:0]     o_data;
  logic              o_mem_wr, o_mem_rd;
  logic [LGFLEN:0]   o_mem_wr_addr, o_mem_rd_addr;
  logic [BW-1:0]     o_mem_data, i_mem_data;

  always #5 clk = ~clk;

  sfifo_sp_ctrl #(.BW(BW), .LGFLEN(LGFLEN)) dut (
    .i_clk         (clk),
    .i_reset_n     (i_reset_n),
    .i_wr          (i_wr),
    .i_data        (i_data),
    .o_full        (o_full),
    .o_ovf         (o_ovf),
    .o_fill        (o_fill),
    .o_valid       (o_valid),
    .o_data        (o_data),
    .i_ready       (i_ready),
    .o_mem_wr      (o_mem_wr),
    .o_mem_wr_addr (o_mem_wr_addr),
    .o_mem_data    (o_mem_data),
    .o_mem_rd      (o_mem_rd),
    .o_mem_rd_addr (o_mem_rd_addr),
    .i_mem_data    (i_mem_data)
  );

  // Single-port SRAM model: read data valid the cycle after the read strobe.
  logic [BW-1:0] sram [DEPTH];
  logic [BW-1:0] mem_q = '0;
  always @(posedge clk) begin
    if (o_mem_wr) sram[o_mem_wr_addr[LGFLEN-1:0]] <= o_mem_data;
    if (o_mem_rd) mem_q <= sram[o_mem_rd_addr[LGFLEN-1:0]];
  end
  assign i_mem_data = mem_q;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Scoreboard and reference model, sampled on the falling edge.
  logic [BW-1:0]     sb [$];
  int                fill_m = 0;
  logic              wbv_m = 1'b0;
  logic [LGFLEN-1:0] wa_m = '0, ra_m = '0;
  logic              stall_m = 1'b0;
  logic [BW-1:0]     stall_d = '0;
  logic              exp_full, acc, pop;
  int                n_wr_gnt = 0, n_rd_gnt = 0, n_popped = 0;

  always @(negedge clk) begin
    if (!i_reset_n) begin
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_fill", 64'(o_fill), 64'd0);
      chk("rst_mem_rd", 64'(o_mem_rd), 64'd0);
      chk("rst_mem_wr", 64'(o_mem_wr), 64'd0);
      chk("rst_full", 64'(o_full), 64'd1);
      chk("rst_ovf", 64'(o_ovf), 64'd0);
      sb.delete();
      fill_m  = 0;
      wbv_m   = 1'b0;
      wa_m    = '0;
      ra_m    = '0;
      stall_m = 1'b0;
    end else begin
      exp_full = wbv_m && !o_mem_wr;
      acc      = i_wr && !exp_full;
      pop      = o_valid && i_ready;
      chk("full", 64'(o_full), 64'(exp_full));
      chk("ovf", 64'(o_ovf), 64'(i_wr && exp_full));
      chk("fill", 64'(o_fill), 64'(fill_m));
      chk("one_access", 64'(o_mem_wr && o_mem_rd), 64'd0);
      if (o_mem_wr) begin
        chk("wr_addr", 64'(o_mem_wr_addr), 64'({1'b0, wa_m}));
        wa_m++;
        n_wr_gnt++;
      end
      if (o_mem_rd) begin
        chk("rd_addr", 64'(o_mem_rd_addr), 64'({1'b0, ra_m}));
        ra_m++;
        n_rd_gnt++;
      end
      if (stall_m) begin
        chk("stall_valid", 64'(o_valid), 64'd1);
        chk("stall_data", 64'(o_data), 64'(stall_d));
      end
      if (pop) begin
        n_popped++;
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL pop_empty: got word %0h, expected no word", o_data);
        end else begin
          chk("data", 64'(o_data), 64'(sb.pop_front()));
        end
      end
      if (acc) sb.push_back(i_data);
      stall_m = o_valid && !i_ready;
      stall_d = o_data;
      fill_m  = fill_m + int'(acc) - int'(pop);
      if (acc) wbv_m = 1'b1;
      else if (o_mem_wr) wbv_m = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [BW-1:0] d);
    bit done = 1'b0;
    i_wr   = 1'b1;
    i_data = d;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      done = !o_full;
      tick();
    end
    i_wr = 1'b0;
    if (!done) begin
      n_total++;
      $display("FAIL push_timeout: word %0h still blocked, expected acceptance", d);
    end
  endtask

  task automatic drain();
    bit empty = 1'b0;
    i_ready = 1'b1;
    for (int i = 0; i < 300 && !empty; i++) begin
      @(negedge clk);
      empty = (o_fill == '0) && (sb.size() == 0);
      tick();
    end
    if (!empty) begin
      n_total++;
      $display("FAIL drain_timeout: fill %0d, expected 0", o_fill);
    end
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    tick();
    i_reset_n = 1'b1;
  endtask

  typedef struct {
    logic          wr;
    logic [BW-1:0] data;
    logic          ready;
    logic          e_wr, e_rd, e_valid, e_full;
    int            e_fill;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int p0, wr0, rd0, acc_n;
    logic [BW-1:0] cnt;
    bit seen, wdone;

    vecs[0] = '{1'b1, 48'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[1] = '{1'b0, 48'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[2] = '{1'b0, 48'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[3] = '{1'b0, 48'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[4] = '{1'b0, 48'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[5] = '{1'b0, 48'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};

    i_reset_n = 1'b0;
    i_wr      = 1'b0;
    i_data    = '0;
    i_ready   = 1'b0;
    tick();
    tick();
    i_reset_n = 1'b1;

    // 1: single-word latency, table driven
    for (int i = 0; i < 6; i++) begin
      i_wr    = vecs[i].wr;
      i_data  = vecs[i].data;
      i_ready = vecs[i].ready;
      @(negedge clk);
      chk($sformatf("t1_mem_wr[%0d]", i), 64'(o_mem_wr), 64'(vecs[i].e_wr));
      chk($sformatf("t1_mem_rd[%0d]", i), 64'(o_mem_rd), 64'(vecs[i].e_rd));
      chk($sformatf("t1_valid[%0d]", i), 64'(o_valid), 64'(vecs[i].e_valid));
      chk($sformatf("t1_full[%0d]", i), 64'(o_full), 64'(vecs[i].e_full));
      chk($sformatf("t1_fill[%0d]", i), 64'(o_fill), 64'(vecs[i].e_fill));
      if (vecs[i].e_valid) chk("t1_data", 64'(o_data), 64'hA5);
      tick();
    end
    i_wr = 1'b0;

    // 2: fill to capacity, overflow, drain in order
    i_ready = 1'b0;
    for (int k = 1; k <= 19; k++) push_word(BW'(k));
    repeat (6) tick();
    @(negedge clk);
    chk("t2_full", 64'(o_full), 64'd1);
    chk("t2_fill", 64'(o_fill), 64'd19);
    tick();
    i_wr   = 1'b1;
    i_data = BW'(20);
    @(negedge clk);
    chk("t2_ovf", 64'(o_ovf), 64'd1);
    tick();
    i_wr = 1'b0;
    @(negedge clk);
    chk("t2_ovf_clear", 64'(o_ovf), 64'd0);
    chk("t2_fill_kept", 64'(o_fill), 64'd19);
    tick();
    p0 = n_popped;
    drain();
    chk("t2_popped", 64'(n_popped - p0), 64'd19);

    // 3: sustained concurrent write and read
    i_ready = 1'b1;
    i_wr    = 1'b1;
    cnt     = BW'(1000);
    wr0     = n_wr_gnt;
    rd0     = n_rd_gnt;
    for (int c = 0; c < 200; c++) begin
      i_data = cnt;
      @(negedge clk);
      if (!o_full) cnt++;
      tick();
    end
    i_wr  = 1'b0;
    acc_n = int'(cnt) - 1000;
    chk("t3_accept_rate", 64'(acc_n >= 95 && acc_n <= 105), 64'd1);
    chk("t3_wr_rate", 64'((n_wr_gnt - wr0) >= 95 && (n_wr_gnt - wr0) <= 105), 64'd1);
    chk("t3_rd_rate", 64'((n_rd_gnt - rd0) >= 95 && (n_rd_gnt - rd0) <= 105), 64'd1);
    drain();

    // 4: random back-pressure across several pointer wraps
    wr0   = n_wr_gnt;
    rd0   = n_rd_gnt;
    p0    = n_popped;
    wdone = 1'b0;
    fork
      begin
        for (int k = 0; k < 100; k++) begin
          push_word(BW'(2000 + k));
          repeat ($urandom_range(0, 1)) tick();
        end
        wdone = 1'b1;
      end
      begin
        while (!wdone) begin
          i_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    drain();
    chk("t4_mem_writes", 64'(n_wr_gnt - wr0), 64'd100);
    chk("t4_mem_reads", 64'(n_rd_gnt - rd0), 64'd100);
    chk("t4_popped", 64'(n_popped - p0), 64'd100);

    // 5: stall pattern 1,0,0,1 with prefetch returns landing during stalls
    i_ready = 1'b0;
    for (int k = 0; k < 6; k++) push_word(BW'(3000 + k));
    repeat (5) tick();
    p0 = n_popped;
    for (int c = 0; c < 24; c++) begin
      i_ready = (c % 4 == 0) || (c % 4 == 3);
      tick();
    end
    drain();
    chk("t5_popped", 64'(n_popped - p0), 64'd6);

    // 6: reset with stored words and a read in flight
    i_ready = 1'b0;
    for (int k = 0; k < 10; k++) push_word(BW'(4000 + k));
    repeat (4) tick();
    i_ready = 1'b1;
    seen    = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = o_mem_rd;
      tick();
    end
    chk("t6_read_issued", 64'(seen), 64'd1);
    i_ready = 1'b0;
    do_reset();
    @(negedge clk);
    chk("t6_valid", 64'(o_valid), 64'd0);
    chk("t6_fill", 64'(o_fill), 64'd0);
    chk("t6_mem_rd", 64'(o_mem_rd), 64'd0);
    tick();
    push_word(BW'(48'h3C));
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = o_valid;
      if (seen) chk("t6_first_word", 64'(o_data), 64'h3C);
      tick();
    end
    chk("t6_word_out", 64'(seen), 64'd1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
